// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: per-lane memory-stage and commit bundles,
// the control struct, access-size encodings and a small popcount helper.
`default_nettype none

package writeback_stage_pkg;

  localparam int NLANE_DEFAULT = 2;
  localparam int XLEN_DEFAULT  = 64;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_D = 2'd3
  } msize_t;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memunsigned;
    msize_t msize;
  } ctl_t;

  typedef struct packed {
    logic [63:0]             pc;
    logic [31:0]             raw_instr;
    logic [4:0]              dst;
    ctl_t                    ctl;
    logic [XLEN_DEFAULT-1:0] aluout;
    logic [XLEN_DEFAULT-1:0] readdata;
    logic [XLEN_DEFAULT-1:0] addr;
  } memory_data_t;

  typedef struct packed {
    logic [63:0]             pc;
    logic [31:0]             raw_instr;
    logic [4:0]              dst;
    ctl_t                    ctl;
    logic [XLEN_DEFAULT-1:0] writedata;
    logic                    wen;
  } writeback_data_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/writeback_stage_if.sv
// Memory-stage input handshake and commit-side output bundle of the writeback stage.
`default_nettype none

interface writeback_stage_if
  import writeback_stage_pkg::*;
#(
  parameter int NLANE = NLANE_DEFAULT
) ();

  logic [NLANE-1:0] in_valid;
  memory_data_t     in_data [NLANE];
  logic             in_ready;
  logic             flush;
  logic             wb_ready;
  logic [NLANE-1:0] wb_valid;
  writeback_data_t  wb_data [NLANE];

  modport master (
    output in_valid, in_data, flush, wb_ready,
    input  in_ready, wb_valid, wb_data
  );

  modport slave (
    input  in_valid, in_data, flush, wb_ready,
    output in_ready, wb_valid, wb_data
  );

endinterface

`default_nettype wire

// File: rtl/writeback_stage_load_extend.sv
// Aligns a doubleword read to the byte offset, truncates to the access size and extends.
`default_nettype none

module load_extend
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] readdata,
  input  logic [2:0]      addr,
  input  msize_t          msize,
  input  logic            memunsigned,
  output logic [XLEN-1:0] word
);

  logic [XLEN-1:0] shifted;

  assign shifted = readdata >> {addr, 3'b000};

  always_comb begin
    word = shifted;
    case (msize)
      MSIZE_B: word = {{(XLEN-8){~memunsigned & shifted[7]}},   shifted[7:0]};
      MSIZE_H: word = {{(XLEN-16){~memunsigned & shifted[15]}}, shifted[15:0]};
      MSIZE_W: word = {{(XLEN-32){~memunsigned & shifted[31]}}, shifted[31:0]};
      default: word = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// Single-entry commit buffer for NLANE parallel results; forms register writes and counts retirements.
`default_nettype none

module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int NLANE = NLANE_DEFAULT,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  writeback_stage_if.slave  bus,
  output logic [63:0]       instret
);

  logic [NLANE-1:0] held_valid;
  memory_data_t     held_data [NLANE];
  logic [XLEN-1:0]  load_ext  [NLANE];
  writeback_data_t  wb_lane   [NLANE];
  logic [NLANE-1:0] wb_valid_w;
  logic             any_held;
  logic             accept;

  assign any_held     = |held_valid;
  assign bus.in_ready = !any_held || bus.wb_ready || bus.flush;
  assign accept       = (|bus.in_valid) && bus.in_ready;
  assign wb_valid_w   = held_valid & {NLANE{!bus.flush}};
  assign bus.wb_valid = wb_valid_w;
  assign bus.wb_data  = wb_lane;

  // A flushed accept still loads, but with every lane invalidated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_valid <= '0;
      for (int i = 0; i < NLANE; i++) begin
        held_data[i] <= '0;
      end
    end else if (accept) begin
      held_valid <= bus.in_valid & {NLANE{!bus.flush}};
      for (int i = 0; i < NLANE; i++) begin
        held_data[i] <= bus.in_data[i];
      end
    end else if (bus.flush || bus.wb_ready) begin
      held_valid <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instret <= '0;
    end else if (bus.wb_ready) begin
      instret <= instret + 64'(popcount4(4'(wb_valid_w)));
    end
  end

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    load_extend #(
      .XLEN (XLEN)
    ) u_load_extend (
      .readdata    (held_data[i].readdata),
      .addr        (held_data[i].addr[2:0]),
      .msize       (held_data[i].ctl.msize),
      .memunsigned (held_data[i].ctl.memunsigned),
      .word        (load_ext[i])
    );
  end

  // Higher lane is the younger instruction, so it wins a same-register write.
  always_comb begin
    for (int i = 0; i < NLANE; i++) begin
      wb_lane[i].pc        = held_data[i].pc;
      wb_lane[i].raw_instr = held_data[i].raw_instr;
      wb_lane[i].dst       = held_data[i].dst;
      wb_lane[i].ctl       = held_data[i].ctl;
      if (held_data[i].dst == 5'd0) begin
        wb_lane[i].writedata = '0;
        wb_lane[i].wen       = 1'b0;
      end else begin
        wb_lane[i].writedata = held_data[i].ctl.memread ? load_ext[i] : held_data[i].aluout;
        wb_lane[i].wen       = held_data[i].ctl.regwrite;
      end
      for (int j = i + 1; j < NLANE; j++) begin
        if (held_valid[j] && held_data[j].ctl.regwrite &&
            held_data[j].dst == held_data[i].dst && held_data[i].dst != 5'd0) begin
          wb_lane[i].wen = 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: accept/commit, loads, back-pressure, conflicts, flush, reset, wrap.
`default_nettype none

module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int NL = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] instret;
  int          checks   = 0;
  int          failures = 0;

  writeback_stage_if #(.NLANE(NL)) bus ();

  writeback_stage #(.NLANE(NL), .XLEN(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .instret (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic memory_data_t mk(input logic [4:0] dst, input logic rw, input logic mr,
                                      input logic mu, input msize_t ms, input logic [63:0] alu,
                                      input logic [63:0] rd, input logic [63:0] ad);
    memory_data_t m;
    m = '0;
    m.pc = 64'h1000 + {59'd0, dst};
    m.raw_instr = 32'h13;
    m.dst = dst;
    m.ctl.regwrite = rw;
    m.ctl.memread = mr;
    m.ctl.memunsigned = mu;
    m.ctl.msize = ms;
    m.aluout = alu;
    m.readdata = rd;
    m.addr = ad;
    return m;
  endfunction

  initial begin
    reset_n = 1'b0;
    bus.in_valid = '0;
    bus.flush = 1'b0;
    bus.wb_ready = 1'b0;
    bus.in_data[0] = '0;
    bus.in_data[1] = '0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_wdata0", bus.wb_data[0].writedata, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // single lane ALU result
    bus.in_valid = 2'b01;
    bus.in_data[0] = mk(5'd5, 1'b1, 1'b0, 1'b0, MSIZE_D, 64'h1234, 64'd0, 64'd0);
    bus.wb_ready = 1'b1;
    tick();
    chk("alu_valid", 64'(bus.wb_valid), 64'd1);
    chk("alu_wdata", bus.wb_data[0].writedata, 64'h1234);
    chk("alu_wen", 64'(bus.wb_data[0].wen), 64'd1);
    bus.in_valid = 2'b00;
    tick();
    chk("alu_instret", instret, 64'd1);
    chk("alu_drained", 64'(bus.wb_valid), 64'd0);

    // byte loads from offset 7, signed and unsigned
    bus.in_valid = 2'b11;
    bus.in_data[0] = mk(5'd1, 1'b1, 1'b1, 1'b0, MSIZE_B, 64'd0, 64'h80FF_0000_0000_0000, 64'h7);
    bus.in_data[1] = mk(5'd2, 1'b1, 1'b1, 1'b1, MSIZE_B, 64'd0, 64'h80FF_0000_0000_0000, 64'h7);
    tick();
    chk("ld_signed", bus.wb_data[0].writedata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("ld_unsigned", bus.wb_data[1].writedata, 64'h80);
    chk("ld_wen", 64'({bus.wb_data[1].wen, bus.wb_data[0].wen}), 64'd3);
    bus.in_valid = 2'b00;
    tick();
    chk("ld_instret", instret, 64'd3);

    // back-pressure
    bus.wb_ready = 1'b0;
    bus.in_valid = 2'b01;
    bus.in_data[0] = mk(5'd7, 1'b1, 1'b0, 1'b0, MSIZE_D, 64'hAAAA, 64'd0, 64'd0);
    tick();
    chk("bp_held", 64'(bus.wb_valid), 64'd1);
    bus.in_data[0] = mk(5'd8, 1'b1, 1'b0, 1'b0, MSIZE_D, 64'hBBBB, 64'd0, 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("bp_wdata", bus.wb_data[0].writedata, 64'hAAAA);
      chk("bp_instret", instret, 64'd3);
    end
    bus.wb_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("bp_next_wdata", bus.wb_data[0].writedata, 64'hBBBB);
    chk("bp_next_valid", 64'(bus.wb_valid), 64'd1);
    chk("bp_commit1", instret, 64'd4);
    bus.in_valid = 2'b00;
    tick();
    chk("bp_commit2", instret, 64'd5);

    // same destination conflict, then dst=0
    bus.in_valid = 2'b11;
    bus.in_data[0] = mk(5'd3, 1'b1, 1'b0, 1'b0, MSIZE_D, 64'h11, 64'd0, 64'd0);
    bus.in_data[1] = mk(5'd3, 1'b1, 1'b0, 1'b0, MSIZE_D, 64'h22, 64'd0, 64'd0);
    tick();
    chk("cf_wen0", 64'(bus.wb_data[0].wen), 64'd0);
    chk("cf_wen1", 64'(bus.wb_data[1].wen), 64'd1);
    chk("cf_wdata1", bus.wb_data[1].writedata, 64'h22);
    bus.in_data[0] = mk(5'd0, 1'b1, 1'b0, 1'b0, MSIZE_D, 64'h55, 64'd0, 64'd0);
    bus.in_data[1] = mk(5'd9, 1'b1, 1'b0, 1'b0, MSIZE_D, 64'h66, 64'd0, 64'd0);
    tick();
    chk("cf_instret", instret, 64'd7);
    chk("z_wdata0", bus.wb_data[0].writedata, 64'd0);
    chk("z_wen0", 64'(bus.wb_data[0].wen), 64'd0);
    chk("z_wdata1", bus.wb_data[1].writedata, 64'h66);
    chk("z_wen1", 64'(bus.wb_data[1].wen), 64'd1);

    // flush with held bundle, new offer and wb_ready together
    bus.flush = 1'b1;
    bus.in_data[0] = mk(5'd10, 1'b1, 1'b0, 1'b0, MSIZE_D, 64'h99, 64'd0, 64'd0);
    #1;
    chk("fl_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 2'b00;
    #1;
    chk("fl_empty", 64'(bus.wb_valid), 64'd0);
    chk("fl_instret", instret, 64'd7);

    // asynchronous reset mid-bundle
    bus.wb_ready = 1'b0;
    bus.in_valid = 2'b01;
    bus.in_data[0] = mk(5'd4, 1'b1, 1'b0, 1'b0, MSIZE_D, 64'h77, 64'd0, 64'd0);
    tick();
    chk("ar_held", 64'(bus.wb_valid), 64'd1);
    bus.in_valid = 2'b00;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("ar_instret", instret, 64'd0);
    chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
    chk("ar_wdata", bus.wb_data[0].writedata, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // counter wrap
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    bus.wb_ready = 1'b1;
    bus.in_valid = 2'b11;
    bus.in_data[0] = mk(5'd11, 1'b1, 1'b0, 1'b0, MSIZE_D, 64'h1, 64'd0, 64'd0);
    bus.in_data[1] = mk(5'd12, 1'b1, 1'b0, 1'b0, MSIZE_D, 64'h2, 64'd0, 64'd0);
    tick();
    chk("wrap_pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.in_valid = 2'b00;
    tick();
    chk("wrap_post", instret, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
